// File: rtl/delta_sigma_pkg.sv
// rtl/delta_sigma_pkg.sv - shared constants for the pulse-density modulator
package delta_sigma_pkg;

  // Default level/accumulator width; output resolution is 1/2^BITS.
  localparam int DS_BITS_DEFAULT = 5;

endpackage : delta_sigma_pkg

// File: rtl/delta_sigma.sv
// rtl/delta_sigma.sv - first-order delta-sigma modulator, level in, 1-bit stream out
module delta_sigma
  import delta_sigma_pkg::*;
#(
  parameter int BITS = DS_BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] data_in,
  input  logic            data_in_en,
  input  logic            next,
  output logic            out
);

  logic [BITS-1:0] level_q;
  logic [BITS-1:0] acc_q;
  logic [BITS-1:0] acc_d;
  logic            out_q;
  logic            out_d;

  // One modulator step: accumulator wraps modulo 2^BITS and the carry is the output bit.
  // A step taken on the same edge as a load still sees the old level_q.
  always_comb begin
    {out_d, acc_d} = {1'b0, acc_q} + {1'b0, level_q};
  end

  // Level register: loads independently of stepping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
    end else if (data_in_en) begin
      level_q <= data_in;
    end
  end

  // Accumulator: advances only on a step strobe, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (next) begin
      acc_q <= acc_d;
    end
  end

  // Output register: static level that changes only when a step is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= 1'b0;
    end else if (next) begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : delta_sigma

// File: tb/tb_delta_sigma.sv
// tb/tb_delta_sigma.sv - randomized and directed self-checking bench for delta_sigma
module tb_delta_sigma;

  localparam int BITS = 5;
  localparam int M    = 1 << BITS;

  logic            clk = 1'b0;
  logic            rst;
  logic [BITS-1:0] data_in;
  logic            data_in_en;
  logic            next;
  logic            out;

  always #5 clk = ~clk;

  delta_sigma #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_in_en(data_in_en),
    .next      (next),
    .out       (out)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: total running sum of levels applied since reset.
  // The output bit of a step is whether that step crossed a multiple of 2^BITS.
  longint total;
  int     lvl;
  logic   exp_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    total   = 0;
    lvl     = 0;
    exp_out = 1'b0;
  endtask

  // Called at posedge+1; drives inputs, advances one edge, updates model, checks out.
  task automatic cycle(input logic en, input logic [BITS-1:0] d, input logic nx, input string tag);
    data_in    = d;
    data_in_en = en;
    next       = nx;
    @(posedge clk);
    if (nx) begin
      exp_out = ((total + lvl) / M) != (total / M);
      total   = total + lvl;
    end
    if (en) lvl = int'(d);
    #1;
    check(tag, {31'd0, out}, {31'd0, exp_out});
  endtask

  // Async reset applied away from the clock edge; out must drop before the next edge.
  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #2;
    check({tag, "_async"}, {31'd0, out}, 32'd0);
    data_in    = '1;
    data_in_en = 1'b1;
    next       = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check({tag, "_held"}, {31'd0, out}, 32'd0);
    end
    rst        = 1'b1;
    data_in_en = 1'b0;
    next       = 1'b0;
    model_reset();
  endtask

  // From reset, load L and count ones over one full 2^BITS-step window.
  task automatic window(input int l, input string tag);
    int ones;
    pulse_reset({tag, "_rst"});
    cycle(1'b1, l[BITS-1:0], 1'b0, {tag, "_load"});
    ones = 0;
    for (int i = 0; i < M; i++) begin
      cycle(1'b0, '0, 1'b1, tag);
      ones += int'(out);
    end
    check({tag, "_ones"}, ones, l);
  endtask

  initial begin
    int first_one;
    int ones;
    model_reset();
    rst        = 1'b1;
    data_in    = '0;
    data_in_en = 1'b0;
    next       = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("reset_out", {31'd0, out}, 32'd0);

    // Inputs toggling while in reset must have no effect.
    for (int i = 0; i < 4; i++) begin
      data_in    = BITS'(31 - i);
      data_in_en = i[0];
      next       = ~i[0];
      @(posedge clk);
      #1;
      check("in_reset", {31'd0, out}, 32'd0);
    end
    rst        = 1'b1;
    data_in_en = 1'b0;
    next       = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, "post_rst_idle");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "post_rst_l0");

    // L=7: first one on step 5, 7 ones per 32 steps.
    pulse_reset("l7");
    cycle(1'b1, 5'd7, 1'b0, "l7_load");
    first_one = 0;
    ones      = 0;
    for (int i = 1; i <= M; i++) begin
      cycle(1'b0, '0, 1'b1, "l7_step");
      if (out === 1'b1 && first_one == 0) first_one = i;
      ones += int'(out);
    end
    check("l7_first_one", first_one, 5);
    check("l7_ones", ones, 7);

    // L=16 alternates 0,1,0,1 from A=0.
    pulse_reset("l16");
    cycle(1'b1, 5'd16, 1'b0, "l16_load");
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, '0, 1'b1, "l16_step");
      check("l16_alt", {31'd0, out}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    window(0, "l0");
    window(31, "l31");
    window(16, "l16w");

    // Freeze for 10 cycles mid-stream, then resume the exact sequence.
    pulse_reset("hold");
    cycle(1'b1, 5'd11, 1'b0, "hold_load");
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, "hold_pre");
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, "hold_idle");
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, "hold_post");

    // Load 7->24 on the same edge as a step: that step adds 7, the next adds 24.
    pulse_reset("same");
    cycle(1'b1, 5'd7, 1'b0, "same_load7");
    cycle(1'b0, '0, 1'b1, "same_s1");
    check("same_s1_out", {31'd0, out}, 32'd0);
    cycle(1'b1, 5'd24, 1'b1, "same_s2");
    check("same_s2_out", {31'd0, out}, 32'd0);
    cycle(1'b0, '0, 1'b1, "same_s3");
    check("same_s3_out", {31'd0, out}, 32'd1);

    // Mid-stream reset while out is high.
    for (int i = 0; i < 4 && out !== 1'b1; i++) cycle(1'b0, '0, 1'b1, "mid_seek");
    check("mid_out_high", {31'd0, out}, 32'd1);
    pulse_reset("mid");
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, "mid_after");

    // Randomized mix of loads, steps and idles against the model.
    for (int i = 0; i < 600; i++) begin
      logic en;
      logic nx;
      en = ($urandom_range(0, 7) == 0);
      nx = ($urandom_range(0, 3) != 0);
      cycle(en, BITS'($urandom), nx, "rand");
      if ($urandom_range(0, 199) == 0) pulse_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_delta_sigma
